// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryptor, UNROLL rounds per clock with on-the-fly key expansion.
// Define AES_ROUND_TAP_EN to add the round_out/round_idx debug taps.
module aes_encrypt_iter #(
  parameter int UNROLL = 1,
  parameter int NR     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plain_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_text,
`ifdef AES_ROUND_TAP_EN
  output logic [127:0] round_out,
  output logic [3:0]   round_idx,
`endif
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t       state_q, state_d;
  logic [127:0] st_q, st_d, rkey_q, rkey_d, ct_q, ct_d, st_n, key_n;
  logic [3:0]   rnd_q, rnd_d;
  logic         last;
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5)) begin : g_bad_unroll
    $error("aes_encrypt_iter: UNROLL must be 1, 2 or 5");
  end
  if (NR != 10) begin : g_bad_nr
    $error("aes_encrypt_iter: NR must be 10");
  end
  function automatic logic [7:0] sbox(input logic [7:0] a);
    sbox = 8'h00;
    case (a)
      8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
      8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
      8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
      8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
      8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
      8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
      8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
      8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
      8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
      8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
      8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
      8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
      8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
      8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
      8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
      8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
      8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
      8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
      8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
      8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
      8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
      8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
      8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
      8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
      8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
      8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
      8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
      8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
      8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
      8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
      8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
      8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
      default: sbox = 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return r == 4'd9 ? 8'h1b : r == 4'd10 ? 8'h36 : 8'h01 << (r - 4'd1);
  endfunction
  // Byte 4c+r of the block sits at row r, column c; ShiftRows pulls row r from column c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        o[127-8*(4*c+j) -: 8] = sbox(s[127-8*(4*((c+j)%4)+j) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction
  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    return {n0, n1, n2, k[31:0] ^ n2};
  endfunction
  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    logic [3:0]   r;
    logic [127:0] st_in, k_in, ss, k_o, st_o;
    if (i == 0) begin : g_first
      assign st_in = st_q;
      assign k_in  = rkey_q;
    end else begin : g_next
      assign st_in = g_rnd[i-1].st_o;
      assign k_in  = g_rnd[i-1].k_o;
    end
    assign r    = rnd_q + 4'(i);
    assign k_o  = key_exp(k_in, rcon(r));
    assign ss   = sub_shift(st_in);
    assign st_o = (r == 4'd10 ? ss : mix(ss)) ^ k_o;
  end
  assign st_n  = g_rnd[UNROLL-1].st_o;
  assign key_n = g_rnd[UNROLL-1].k_o;
  assign last  = rnd_q == 4'(NR + 1 - UNROLL);
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rkey_d  = rkey_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = ROUND;
        st_d    = plain_text ^ key;
        rkey_d  = key;
        rnd_d   = 4'd1;
      end
      ROUND: begin
        st_d   = st_n;
        rkey_d = key_n;
        rnd_d  = last ? 4'd0 : rnd_q + 4'(UNROLL);
        if (last) begin
          ct_d    = st_n;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rkey_q  <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rkey_q  <= rkey_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign cipher_text = ct_q;
`ifdef AES_ROUND_TAP_EN
  assign round_out = state_q == ROUND ? st_n : '0;
  assign round_idx = state_q == ROUND ? rnd_q + 4'(UNROLL - 1) : '0;
`endif
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: known-answer, handshake, reset and randomized checks against a byte-level AES model.
module tb_aes_encrypt_iter;
  parameter int U = 1;
  localparam int LAT = 10 / U;
  localparam logic [127:0] V1_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V1_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V1_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V1_R1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] V2_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V3_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic         in_ready, out_valid, busy;
  logic [127:0] plain_text = '0, key = '0, cipher_text;
`ifdef AES_ROUND_TAP_EN
  logic [127:0] round_out;
  logic [3:0]   round_idx;
`endif
  int checks = 0, failures = 0;
  logic [7:0] sb [256];
  always #5 clk = ~clk;
  aes_encrypt_iter #(.UNROLL(U)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plain_text(plain_text), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .cipher_text(cipher_text),
`ifdef AES_ROUND_TAP_EN
    .round_out(round_out), .round_idx(round_idx),
`endif
    .busy(busy)
  );
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00, x, s;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv;
      x = inv;
      for (int k = 0; k < 4; k++) begin
        x = {x[6:0], x[7]};
        s ^= x;
      end
      sb[a] = s ^ 8'h63;
    end
  endtask
  // State after the given number of rounds (10 gives the ciphertext).
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k, input int rounds);
    logic [7:0]  s [16], t [16], a [4], rc;
    logic [31:0] w [44], tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= rounds; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++) for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(8'h02, a[j]) ^ gmul(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
      for (int c = 0; c < 4; c++) for (int j = 0; j < 4; j++) s[4*c+j] ^= w[4*r+c][31-8*j -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [127:0] pt, input logic [127:0] k);
    int n = 0;
    logic acc;
    plain_text = pt;
    key = k;
    in_valid = 1;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    in_valid = 0;
    plain_text = {$urandom(), $urandom(), $urandom(), $urandom()};
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  task automatic recv(output logic [127:0] ct);
    ct = cipher_text;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (cipher_text !== '0) begin failures++; $display("FAIL reset_ct got=%h exp=0", cipher_text); end
    rst_n = 1;
    tick();
  endtask
  task automatic test_known(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp_ct);
    int lat;
    logic [127:0] ct;
    accept(pt, k);
    wait_out(lat);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL latency got=%0d exp=%0d", lat, LAT); end
    recv(ct);
    checks++;
    if (ct !== exp_ct) begin failures++; $display("FAIL known_ct got=%h exp=%h", ct, exp_ct); end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL after_handshake out_valid/in_ready got=%b exp=01", {out_valid, in_ready});
    end
  endtask
  task automatic test_hold();
    int lat;
    logic [127:0] ct;
    accept('0, '0);
    wait_out(lat);
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({out_valid, in_ready, busy, cipher_text} !== {3'b101, V3_CT}) begin
        failures++;
        $display("FAIL hold cyc=%0d valid/ready/busy=%b ct=%h exp=101 %h", i, {out_valid, in_ready, busy}, cipher_text, V3_CT);
      end
      tick();
    end
    in_valid = 0;
    recv(ct);
    checks++;
    if (ct !== V3_CT) begin failures++; $display("FAIL hold_ct got=%h exp=%h", ct, V3_CT); end
  endtask
  task automatic test_back_to_back();
    int lat1, lat2, n = 0;
    logic [127:0] ct1, ct2;
    out_ready = 1;
    plain_text = V1_PT;
    key = V1_K;
    in_valid = 1;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    plain_text = V2_PT;
    key = V2_K;
    wait_out(lat1);
    ct1 = cipher_text;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_idle_gap out_valid/in_ready got=%b exp=01", {out_valid, in_ready});
    end
    tick();
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_second_accept busy/in_ready got=%b exp=10", {busy, in_ready});
    end
    in_valid = 0;
    wait_out(lat2);
    ct2 = cipher_text;
    tick();
    out_ready = 0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_done_one_cycle out_valid got=%b exp=0", out_valid); end
    checks++;
    if (lat1 !== LAT || lat2 !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d,%0d exp=%0d", lat1, lat2, LAT); end
    checks++;
    if (ct1 !== V1_CT) begin failures++; $display("FAIL b2b_ct1 got=%h exp=%h", ct1, V1_CT); end
    checks++;
    if (ct2 !== V2_CT) begin failures++; $display("FAIL b2b_ct2 got=%h exp=%h", ct2, V2_CT); end
  endtask
  task automatic test_reset_mid();
    int lat;
    logic [127:0] ct;
    accept(V1_PT, V1_K);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010 || cipher_text !== '0) begin
      failures++;
      $display("FAIL reset_mid valid/ready/busy=%b ct=%h exp=010 0", {out_valid, in_ready, busy}, cipher_text);
    end
    accept(V2_PT, V2_K);
    wait_out(lat);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL reset_mid_latency got=%0d exp=%0d", lat, LAT); end
    recv(ct);
    checks++;
    if (ct !== V2_CT) begin failures++; $display("FAIL reset_mid_ct got=%h exp=%h", ct, V2_CT); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int lat;
      logic [127:0] pt, k, exp_ct, ct;
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_ct = aes_model(pt, k, 10);
      accept(pt, k);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) tick();
      recv(ct);
      checks++;
      if (ct !== exp_ct) begin failures++; $display("FAIL random_ct n=%0d got=%h exp=%h", n, ct, exp_ct); end
    end
  endtask
`ifdef AES_ROUND_TAP_EN
  task automatic test_tap();
    logic [127:0] ct, exp_r;
    accept(V1_PT, V1_K);
    for (int i = 1; i <= LAT; i++) begin
      exp_r = (i * U == 1) ? V1_R1 : aes_model(V1_PT, V1_K, i * U);
      checks++;
      if (round_idx !== 4'(i * U) || round_out !== exp_r) begin
        failures++;
        $display("FAIL tap step=%0d idx=%0d out=%h exp idx=%0d out=%h", i, round_idx, round_out, i * U, exp_r);
      end
      tick();
    end
    checks++;
    if (round_idx !== '0 || round_out !== '0) begin failures++; $display("FAIL tap_done idx=%0d out=%h exp=0", round_idx, round_out); end
    recv(ct);
    checks++;
    if (ct !== V1_CT) begin failures++; $display("FAIL tap_ct got=%h exp=%h", ct, V1_CT); end
  endtask
`endif
  initial begin
    build_sbox();
    test_reset();
    test_known(V1_PT, V1_K, V1_CT);
    test_known(V2_PT, V2_K, V2_CT);
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AES_ROUND_TAP_EN
    test_tap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
